// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for integer_seq_alu and its iterative shift unit:
//   opcode constants, FSM state encoding and a small opcode helper.
// ----------------------------------------------------------------------------
package alu_pkg;

    localparam int ALU_OP_W = 6;

    localparam logic [ALU_OP_W-1:0] ALU_OP_PLUS          = 6'd0;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SUB           = 6'd1;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SHIFT_LEFT    = 6'd2;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SHIFT_RIGHT   = 6'd3;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SHIFT_RIGHT_A = 6'd4;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SET_LESS_THAN = 6'd5;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SET_LESS_THAN_U = 6'd6;
    localparam logic [ALU_OP_W-1:0] ALU_OP_AND           = 6'd7;
    localparam logic [ALU_OP_W-1:0] ALU_OP_OR            = 6'd8;
    localparam logic [ALU_OP_W-1:0] ALU_OP_XOR           = 6'd9;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic logic is_shift_op(input logic [ALU_OP_W-1:0] op);
        return (op == ALU_OP_SHIFT_LEFT) || (op == ALU_OP_SHIFT_RIGHT) ||
               (op == ALU_OP_SHIFT_RIGHT_A);
    endfunction

endpackage

// File: rtl/int_alu_shift_unit.sv
// ----------------------------------------------------------------------------
// int_alu_shift_unit
//   Iterative shifter: moves SHIFT_STEP bits per cycle until the requested
//   amount is consumed.
//   Ports:
//     clk, reset       clock, synchronous active-high reset
//     start            load value/amt/dir/arith (one-cycle pulse)
//     dir              0 = left, 1 = right
//     arith            right shifts sign-fill when set
//     value, amt       operand and shift amount
//     busy             more than one step still outstanding
//     result, shout    value and last shifted-out bit *after* the step taken
//                      this cycle; valid to capture once busy is low
// ----------------------------------------------------------------------------
module int_alu_shift_unit
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int SHIFT_STEP = 1,
    parameter int AMT_W      = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  dir,
    input  logic                  arith,
    input  logic [DATA_WIDTH-1:0] value,
    input  logic [AMT_W-1:0]      amt,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  shout
);

    localparam int W = DATA_WIDTH;
    localparam logic [AMT_W:0] STEP_C = (AMT_W+1)'(SHIFT_STEP);

    logic [W-1:0]   val_q, val_d;
    logic [AMT_W:0] rem_q, step;
    logic           dir_q, arith_q, shout_q, shout_d;
    logic [W:0]        l_ext, r_ext;
    logic signed [W:0] r_sext;

    // The step is exposed combinationally so the top can capture the final
    // value on the same edge that finishes the shift (latency = steps).
    always_comb begin
        step   = (rem_q > STEP_C) ? STEP_C : rem_q;
        // One guard bit on the far side catches the last bit shifted out.
        l_ext  = {1'b0, val_q} << step;
        r_ext  = {val_q, 1'b0} >> step;
        r_sext = $signed({val_q, 1'b0}) >>> step;
        val_d   = val_q;
        shout_d = shout_q;
        if (step != '0) begin
            if (!dir_q) begin
                val_d   = l_ext[W-1:0];
                shout_d = l_ext[W];
            end else if (arith_q) begin
                val_d   = r_sext[W:1];
                shout_d = r_sext[0];
            end else begin
                val_d   = r_ext[W:1];
                shout_d = r_ext[0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            val_q   <= '0;
            rem_q   <= '0;
            dir_q   <= 1'b0;
            arith_q <= 1'b0;
            shout_q <= 1'b0;
        end else if (start) begin
            val_q   <= value;
            rem_q   <= {1'b0, amt};
            dir_q   <= dir;
            arith_q <= arith;
            shout_q <= 1'b0;
        end else begin
            val_q   <= val_d;
            rem_q   <= rem_q - step;
            shout_q <= shout_d;
        end
    end

    assign busy   = rem_q > STEP_C;
    assign result = val_d;
    assign shout  = shout_d;

endmodule

// File: rtl/integer_seq_alu.sv
// ----------------------------------------------------------------------------
// integer_seq_alu
//   Registered valid/ready integer ALU. Single-cycle ops finish one cycle after
//   accept; shifts iterate in int_alu_shift_unit. Result is held in DONE until
//   out_ready.
//   Ports:
//     clk, reset            clock, synchronous active-high reset
//     in_valid / in_ready   request handshake (ready only in IDLE)
//     alu_op, A, B          opcode (alu_pkg ALU_OP_*) and operands
//     out_valid / out_ready result handshake
//     out, carry            registered result and carry/borrow/shift-out bit
//   Build option ALU_FLAGS_EN adds registered zero/neg/ovf outputs.
// ----------------------------------------------------------------------------
module integer_seq_alu
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ALU_OP_W-1:0]   alu_op,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out,
    output logic                  carry
`ifdef ALU_FLAGS_EN
    ,
    output logic                  zero,
    output logic                  neg,
    output logic                  ovf
`endif
);

    localparam int W     = DATA_WIDTH;
    localparam int AMT_W = $clog2(DATA_WIDTH);

    logic [1:0]          state_q, state_d;
    logic [ALU_OP_W-1:0] op_q;
    logic [W-1:0]        a_q, b_q, out_q, out_d;
    logic                carry_q, carry_d;
    logic                accept, load;
    logic [W:0]          sum_w, diff_w;
    logic [W-1:0]        alu_res;
    logic                alu_c;
    logic                sh_busy, sh_shout;
    logic [W-1:0]        sh_result;

    assign accept = in_valid && (state_q == ST_IDLE);

    // Shifter is loaded straight from the ports on the accept edge so the
    // first step happens in the first EXEC cycle.
    int_alu_shift_unit #(
        .DATA_WIDTH (DATA_WIDTH),
        .SHIFT_STEP (SHIFT_STEP),
        .AMT_W      (AMT_W)
    ) u_shift (
        .clk    (clk),
        .reset  (reset),
        .start  (accept && is_shift_op(alu_op)),
        .dir    (alu_op != ALU_OP_SHIFT_LEFT),
        .arith  (alu_op == ALU_OP_SHIFT_RIGHT_A),
        .value  (A),
        .amt    (B[AMT_W-1:0]),
        .busy   (sh_busy),
        .result (sh_result),
        .shout  (sh_shout)
    );

    // Single-cycle ops on the latched operands.
    always_comb begin
        sum_w   = {1'b0, a_q} + {1'b0, b_q};
        // MSB of the extended difference is the unsigned borrow (A < B).
        diff_w  = {1'b0, a_q} - {1'b0, b_q};
        alu_res = '0;
        alu_c   = 1'b0;
        case (op_q)
            ALU_OP_PLUS:            {alu_c, alu_res} = sum_w;
            ALU_OP_SUB:             {alu_c, alu_res} = diff_w;
            ALU_OP_SET_LESS_THAN:   alu_res[0] = $signed(a_q) < $signed(b_q);
            ALU_OP_SET_LESS_THAN_U: alu_res[0] = a_q < b_q;
            ALU_OP_AND:             alu_res = a_q & b_q;
            ALU_OP_OR:              alu_res = a_q | b_q;
            ALU_OP_XOR:             alu_res = a_q ^ b_q;
            default:                ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        out_d   = alu_res;
        carry_d = alu_c;
        if (is_shift_op(op_q)) begin
            out_d   = sh_result;
            carry_d = sh_shout;
        end
        case (state_q)
            ST_IDLE: if (in_valid) state_d = ST_EXEC;
            ST_EXEC: begin
                if (!is_shift_op(op_q) || !sh_busy) begin
                    load    = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            out_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q <= alu_op;
                a_q  <= A;
                b_q  <= B;
            end
            if (load) begin
                out_q   <= out_d;
                carry_q <= carry_d;
            end
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign out       = out_q;
    assign carry     = carry_q;

`ifdef ALU_FLAGS_EN
    logic ovf_d, zero_q, neg_q, ovf_q;

    // Signed overflow: operands' signs vs. result sign.
    always_comb begin
        ovf_d = 1'b0;
        case (op_q)
            ALU_OP_PLUS: ovf_d = (a_q[W-1] == b_q[W-1]) && (sum_w[W-1]  != a_q[W-1]);
            ALU_OP_SUB:  ovf_d = (a_q[W-1] != b_q[W-1]) && (diff_w[W-1] != a_q[W-1]);
            default:     ovf_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (load) begin
            zero_q <= (out_d == '0);
            neg_q  <= out_d[W-1];
            ovf_q  <= ovf_d;
        end
    end

    assign zero = zero_q;
    assign neg  = neg_q;
    assign ovf  = ovf_q;
`endif

endmodule
